// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One 4-bit CLA group is resolved per stage, and the group carry ripples from stage to stage.
// Stage 0 registers the operands; stages 1..NGROUPS each resolve one group.
`timescale 1ns/1ps
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             out_carry,
  output logic             overflow
);

  localparam int unsigned NGROUPS = WIDTH / 4;

  // Operands travel as far as the last group that reads them.
  logic [WIDTH-1:0] a_q [0:NGROUPS-1];
  logic [WIDTH-1:0] b_q [0:NGROUPS-1];
  logic [WIDTH-1:0] s_q [0:NGROUPS];
  logic             c_q [0:NGROUPS];
  logic             v_q [0:NGROUPS];
  logic             ov_q;

  logic [WIDTH-1:0] s_nxt [1:NGROUPS];
  logic             c_nxt [1:NGROUPS];
  logic             cm_last;
  logic             stall;

  // 4-bit lookahead group: returns {carry into bit 3, carry out, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[3], c[4], p ^ c[3:0]};
  endfunction

  // The whole pipeline freezes while a result is waiting for the downstream.
  assign stall     = v_q[NGROUPS] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = v_q[NGROUPS];
  assign sum       = s_q[NGROUPS];
  assign out_carry = c_q[NGROUPS];
  assign overflow  = ov_q;

  // Group k-1 is resolved from the carry held in stage k-1.
  always_comb begin
    logic [5:0] r;
    r       = '0;
    cm_last = 1'b0;
    for (int unsigned k = 1; k <= NGROUPS; k++) begin
      s_nxt[k] = s_q[k-1];
      c_nxt[k] = 1'b0;
    end
    for (int unsigned k = 1; k <= NGROUPS; k++) begin
      r = cla4(a_q[k-1][4*(k-1) +: 4], b_q[k-1][4*(k-1) +: 4], c_q[k-1]);
      s_nxt[k][4*(k-1) +: 4] = r[3:0];
      c_nxt[k] = r[4];
      if (k == NGROUPS) cm_last = r[5];
    end
  end

  // Pipeline registers; subtraction is folded in as A + ~B + !carry at stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NGROUPS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int unsigned k = 0; k <= NGROUPS; k++) begin
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= b ^ {WIDTH{sub}};
      c_q[0] <= carry ^ sub;
      s_q[0] <= '0;
      for (int unsigned k = 1; k < NGROUPS; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int unsigned k = 1; k <= NGROUPS; k++) begin
        v_q[k] <= v_q[k-1];
        s_q[k] <= s_nxt[k];
        c_q[k] <= c_nxt[k];
      end
      ov_q <= c_nxt[NGROUPS] ^ cm_last;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder at WIDTH=16, 4 and 32 with in-order scoreboards.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;

  logic clk;
  logic rst;

  logic        iv16, ir16, c16, s16, or16, ov16, co16, of16;
  logic [15:0] a16, b16, sum16;
  logic        iv4, ir4, c4, s4, ov4, co4, of4;
  logic [3:0]  a4, b4, sum4;
  logic        iv32, ir32, c32, s32, ov32, co32, of32;
  logic [31:0] a32, b32, sum32;

  logic [33:0] q16[$];
  logic [33:0] q4[$];
  logic [33:0] q32[$];

  int n_vec = 0;
  int n_err = 0;

  pipelined_cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .carry(c16), .sub(s16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .out_carry(co16), .overflow(of16));

  pipelined_cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .carry(c4), .sub(s4), .out_valid(ov4), .out_ready(1'b1), .sum(sum4),
    .out_carry(co4), .overflow(of4));

  pipelined_cla_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .carry(c32), .sub(s32), .out_valid(ov32), .out_ready(1'b1), .sum(sum32),
    .out_carry(co32), .overflow(of32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {overflow, carry-out, sum} from plain integer arithmetic.
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci, input logic sb);
    logic [31:0] mask, xx, yy;
    logic [32:0] r;
    logic        co, ov;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xx   = x & mask;
    yy   = (sb ? ~y : y) & mask;
    r    = {1'b0, xx} + {1'b0, yy} + {32'd0, ci ^ sb};
    co   = r[w];
    ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
    return {ov, co, r[31:0] & mask};
  endfunction

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output scoreboards and the ready invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready16", {33'd0, ir16}, {33'd0, !(ov16 && !or16)});
      if (ov16 && or16) begin
        if (q16.size() == 0) check("out16_unexpected", 34'd1, 34'd0);
        else check("out16", {of16, co16, 16'h0, sum16}, q16.pop_front());
      end
      if (ov4) begin
        if (q4.size() == 0) check("out4_unexpected", 34'd1, 34'd0);
        else check("out4", {of4, co4, 28'h0, sum4}, q4.pop_front());
      end
      if (ov32) begin
        if (q32.size() == 0) check("out32_unexpected", 34'd1, 34'd0);
        else check("out32", {of32, co32, sum32}, q32.pop_front());
      end
    end
  end

  // Offer one beat to the 16-bit DUT until accepted; optionally jitter out_ready.
  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic sb, input logic [33:0] exp, input bit rnd);
    bit done;
    done = 1'b0;
    iv16 = 1'b1; a16 = x; b16 = y; c16 = ci; s16 = sb;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rnd) or16 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ir16) begin
        q16.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    iv16 = 1'b0;
    check("accept16", {33'd0, done}, 34'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (q16.size() != 0 || q4.size() != 0 || q32.size() != 0); n++)
      @(posedge clk);
    #1;
    check("drain16", 34'(q16.size()), 34'd0);
    check("drain4",  34'(q4.size()),  34'd0);
    check("drain32", 34'(q32.size()), 34'd0);
  endtask

  initial begin
    int lat16, lat4, lat32;
    logic [31:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; or16 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0; s16 = 1'b0;
    iv4  = 1'b0; a4  = '0; b4  = '0; c4  = 1'b0; s4  = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; s32 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_outputs16", {ov16, co16, of16, 15'h0, sum16}, 34'd0);
    check("rst_in_ready16", {33'd0, ir16}, 34'd1);
    check("rst_valid4_32", {32'd0, ov4, ov32}, 34'd0);

    // Latency: 1+1 on all three widths at once
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = 16'h0001; b16 = 16'h0001;
    iv4  = 1'b1; a4  = 4'h1;     b4  = 4'h1;
    iv32 = 1'b1; a32 = 32'h1;    b32 = 32'h1;
    q16.push_back(34'h2); q4.push_back(34'h2); q32.push_back(34'h2);
    lat16 = 0; lat4 = 0; lat32 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      iv16 = 1'b0; iv4 = 1'b0; iv32 = 1'b0;
      if (ov16 && lat16 == 0) lat16 = n;
      if (ov4  && lat4  == 0) lat4  = n;
      if (ov32 && lat32 == 0) lat32 = n;
    end
    check("latency16", 34'(lat16), 34'd5);
    check("latency4",  34'(lat4),  34'd2);
    check("latency32", 34'(lat32), 34'd9);

    // Directed carry-chain, overflow and subtract cases
    send16(16'hFFFF, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0001}, 1'b0);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000}, 1'b0);
    send16(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFE}, 1'b0);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF}, 1'b0);
    send16(16'h0000, 16'h0000, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF}, 1'b0);
    drain();

    // Back-to-back random beats with random back-pressure
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      send16(ra[15:0], rb[15:0], rc, rs, model(16, ra, rb, rc, rs), 1'b1);
    end
    or16 = 1'b1;
    drain();

    // Reset mid-flight discards everything in the pipe
    for (int i = 0; i < 3; i++)
      send16(16'(i + 1), 16'h0100, 1'b0, 1'b0, model(16, 32'(i + 1), 32'h0100, 1'b0, 1'b0), 1'b0);
    rst = 1'b1;
    q16.delete(); q4.delete(); q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid16", {33'd0, ov16}, 34'd0);
    check("midrst_sum16", {18'd0, sum16}, 34'd0);
    repeat (10) @(posedge clk);
    #1;

    // Exhaustive 4-bit sweep, both modes, one beat per clock
    for (int i = 0; i < 1024; i++) begin
      iv4 = 1'b1;
      a4 = 4'(i); b4 = 4'(i >> 4); c4 = 1'(i >> 8); s4 = 1'(i >> 9);
      q4.push_back(model(4, 32'(i & 15), 32'((i >> 4) & 15), 1'(i >> 8), 1'(i >> 9)));
      @(posedge clk); #1;
    end
    iv4 = 1'b0;

    // Random 32-bit beats
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      iv32 = 1'b1; a32 = ra; b32 = rb; c32 = rc; s32 = rs;
      q32.push_back(model(32, ra, rb, rc, rs));
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
